// File: rtl/vx_tma_issue_sched_pkg.sv
// Shared constants for the TMA issue scheduler: op encodings, default sizes
// and a width helper.
package vx_tma_issue_sched_pkg;

  localparam int unsigned DEF_NUM_CORES  = 2;
  localparam int unsigned DEF_NUM_WARPS  = 4;
  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_BAR_ADDR_W = 8;

  typedef enum logic [2:0] {
    TMA_OP_SETUP0  = 3'd0,
    TMA_OP_SETUP1  = 3'd1,
    TMA_OP_COORD01 = 3'd2,
    TMA_OP_COORD23 = 3'd3,
    TMA_OP_ISSUE   = 3'd4
  } tma_op_e;

  // ceil(log2(n)), never less than one bit
  function automatic int unsigned up_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_tma_issue_sched_fifo.sv
// Launch queue for the TMA issue scheduler: power-of-two depth FIFO with
// wrap-bit pointers. Simultaneous push and pop are legal even when full,
// because the popped slot is read before the edge that overwrites it.
module vx_tma_issue_sched_fifo
  import vx_tma_issue_sched_pkg::*;
#(
  parameter int unsigned DATAW = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = up_clog2(DEPTH);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_out = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until the pointers make them visible
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/vx_tma_issue_sched.sv
// TMA issue scheduler: round-robin arbitration of per-core TMA requests,
// registered write port into the issue-state block, per-context outstanding
// tracking and an in-order launch queue to the transfer engine.
// Optional feature macro: VX_TMA_ISSUE_PERF_EN enables the saturating
// perf_launches / perf_stalls counters (tied to zero otherwise).
module vx_tma_issue_sched
  import vx_tma_issue_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS    = DEF_NUM_CORES,
  parameter int unsigned NUM_WARPS   = DEF_NUM_WARPS,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned XLEN        = DEF_XLEN,
  parameter int unsigned BAR_ADDR_W  = DEF_BAR_ADDR_W,
  parameter int unsigned WID_BITS    = up_clog2(NUM_WARPS),
  parameter int unsigned CTX_BITS    = up_clog2(NUM_REQS * NUM_WARPS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid,
  output logic [NUM_REQS-1:0]                  req_ready,
  input  logic [NUM_REQS-1:0][2:0]             req_op,
  input  logic [NUM_REQS-1:0][WID_BITS-1:0]    req_wid,
  input  logic [NUM_REQS-1:0][XLEN-1:0]        req_rs1,
  input  logic [NUM_REQS-1:0][XLEN-1:0]        req_rs2,
  input  logic [NUM_REQS-1:0][BAR_ADDR_W-1:0]  req_bar_addr,
  output logic                                 st_fire,
  output logic [2:0]                           st_op,
  output logic [CTX_BITS-1:0]                  st_ctx_idx,
  output logic [XLEN-1:0]                      st_rs1,
  output logic [XLEN-1:0]                      st_rs2,
  output logic [BAR_ADDR_W-1:0]                st_bar_addr,
  output logic                                 launch_valid,
  output logic [CTX_BITS-1:0]                  launch_ctx_idx,
  input  logic                                 launch_ready,
  input  logic                                 done_valid,
  input  logic [CTX_BITS-1:0]                  done_ctx_idx,
  output logic                                 busy,
  output logic [31:0]                          perf_launches,
  output logic [31:0]                          perf_stalls
);

  localparam int unsigned NUM_CTX  = NUM_REQS * NUM_WARPS;
  localparam int unsigned PTR_BITS = up_clog2(NUM_REQS);

  logic [PTR_BITS-1:0]   ptr_q, ptr_d;
  logic [NUM_CTX-1:0]    outstanding_q, outstanding_d;
  logic                  st_fire_q, st_fire_d;
  logic [2:0]            st_op_q, st_op_d;
  logic [CTX_BITS-1:0]   st_ctx_q, st_ctx_d;
  logic [XLEN-1:0]       st_rs1_q, st_rs1_d;
  logic [XLEN-1:0]       st_rs2_q, st_rs2_d;
  logic [BAR_ADDR_W-1:0] st_bar_q, st_bar_d;

  logic [CTX_BITS-1:0]   req_ctx [NUM_REQS];
  logic [NUM_REQS-1:0]   elig;
  logic                  grant_valid;
  logic [PTR_BITS-1:0]   grant_idx;
  logic [CTX_BITS-1:0]   grant_ctx;
  logic                  grant_issue;

  logic                  q_push, q_pop, q_empty, q_full;
  logic                  stall_cycle;

  // Eligibility and round-robin grant starting at the priority pointer
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      req_ctx[i] = CTX_BITS'(i * NUM_WARPS + 32'(req_wid[i]));
      elig[i]    = req_valid[i] && !outstanding_q[req_ctx[i]] &&
                   ((tma_op_e'(req_op[i]) != TMA_OP_ISSUE) || !q_full);
    end
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_BITS'(idx);
      end
    end
    grant_ctx   = req_ctx[grant_idx];
    grant_issue = grant_valid && (tma_op_e'(req_op[grant_idx]) == TMA_OP_ISSUE);
    req_ready   = '0;
    if (grant_valid) req_ready[grant_idx] = 1'b1;
  end

  // Next-state: pointer, write-port capture, outstanding set/clear
  always_comb begin
    ptr_d     = ptr_q;
    st_fire_d = grant_valid;
    st_op_d   = st_op_q;
    st_ctx_d  = st_ctx_q;
    st_rs1_d  = st_rs1_q;
    st_rs2_d  = st_rs2_q;
    st_bar_d  = st_bar_q;
    if (grant_valid) begin
      ptr_d    = (grant_idx == PTR_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
      st_op_d  = req_op[grant_idx];
      st_ctx_d = grant_ctx;
      st_rs1_d = req_rs1[grant_idx];
      st_rs2_d = req_rs2[grant_idx];
      st_bar_d = req_bar_addr[grant_idx];
    end
    // A done and a grant never hit the same set bit: grants need the bit
    // clear and dones only act on set bits, so clear-then-set is safe.
    outstanding_d = outstanding_q;
    if (done_valid && (32'(done_ctx_idx) < NUM_CTX) && outstanding_q[done_ctx_idx])
      outstanding_d[done_ctx_idx] = 1'b0;
    if (grant_issue)
      outstanding_d[grant_ctx] = 1'b1;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      outstanding_q <= '0;
      st_fire_q     <= 1'b0;
      st_op_q       <= '0;
      st_ctx_q      <= '0;
      st_rs1_q      <= '0;
      st_rs2_q      <= '0;
      st_bar_q      <= '0;
    end else begin
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
      st_fire_q     <= st_fire_d;
      st_op_q       <= st_op_d;
      st_ctx_q      <= st_ctx_d;
      st_rs1_q      <= st_rs1_d;
      st_rs2_q      <= st_rs2_d;
      st_bar_q      <= st_bar_d;
    end
  end

  assign st_fire     = st_fire_q;
  assign st_op       = st_op_q;
  assign st_ctx_idx  = st_ctx_q;
  assign st_rs1      = st_rs1_q;
  assign st_rs2      = st_rs2_q;
  assign st_bar_addr = st_bar_q;

  assign q_push       = grant_issue;
  assign q_pop        = launch_valid && launch_ready;
  assign launch_valid = !q_empty;
  assign busy         = !q_empty || (|outstanding_q);
  assign stall_cycle  = (|req_valid) && !grant_valid;

  vx_tma_issue_sched_fifo #(
    .DATAW (CTX_BITS),
    .DEPTH (QUEUE_DEPTH)
  ) launch_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .pop      (q_pop),
    .data_in  (grant_ctx),
    .data_out (launch_ctx_idx),
    .empty    (q_empty),
    .full     (q_full)
  );

`ifdef VX_TMA_ISSUE_PERF_EN
  logic [31:0] perf_launches_q, perf_launches_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating performance counters
  always_comb begin
    perf_launches_d = perf_launches_q;
    perf_stalls_d   = perf_stalls_q;
    if (q_pop && (perf_launches_q != '1))     perf_launches_d = perf_launches_q + 1'b1;
    if (stall_cycle && (perf_stalls_q != '1)) perf_stalls_d   = perf_stalls_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_launches_q <= '0;
      perf_stalls_q   <= '0;
    end else begin
      perf_launches_q <= perf_launches_d;
      perf_stalls_q   <= perf_stalls_d;
    end
  end

  assign perf_launches = perf_launches_q;
  assign perf_stalls   = perf_stalls_q;
`else
  logic unused_stall;
  assign unused_stall  = stall_cycle;
  assign perf_launches = '0;
  assign perf_stalls   = '0;
`endif

`ifndef SYNTHESIS
  // A completion must refer to a context that is actually in flight
  always_ff @(posedge clk) begin
    if (!reset && done_valid)
      assert ((32'(done_ctx_idx) < NUM_CTX) && outstanding_q[done_ctx_idx])
        else $error("done_valid for idle context %0d", done_ctx_idx);
  end
`endif

endmodule

// File: tb/tb_vx_tma_issue_sched.sv
// Directed self-checking bench for vx_tma_issue_sched (2 cores x 4 warps,
// queue depth 4). Inputs change 1ns after the rising edge; outputs are
// compared 5ns after the rising edge.
module tb_vx_tma_issue_sched;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_op;
  logic [1:0][1:0]  req_wid;
  logic [1:0][31:0] req_rs1;
  logic [1:0][31:0] req_rs2;
  logic [1:0][7:0]  req_bar_addr;
  logic             st_fire;
  logic [2:0]       st_op;
  logic [2:0]       st_ctx_idx;
  logic [31:0]      st_rs1;
  logic [31:0]      st_rs2;
  logic [7:0]       st_bar_addr;
  logic             launch_valid;
  logic [2:0]       launch_ctx_idx;
  logic             launch_ready;
  logic             done_valid;
  logic [2:0]       done_ctx_idx;
  logic             busy;
  logic [31:0]      perf_launches;
  logic [31:0]      perf_stalls;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vx_tma_issue_sched #(
    .NUM_REQS    (2),
    .NUM_WARPS   (4),
    .QUEUE_DEPTH (4),
    .XLEN        (32),
    .BAR_ADDR_W  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_wid        (req_wid),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_bar_addr   (req_bar_addr),
    .st_fire        (st_fire),
    .st_op          (st_op),
    .st_ctx_idx     (st_ctx_idx),
    .st_rs1         (st_rs1),
    .st_rs2         (st_rs2),
    .st_bar_addr    (st_bar_addr),
    .launch_valid   (launch_valid),
    .launch_ctx_idx (launch_ctx_idx),
    .launch_ready   (launch_ready),
    .done_valid     (done_valid),
    .done_ctx_idx   (done_ctx_idx),
    .busy           (busy),
    .perf_launches  (perf_launches),
    .perf_stalls    (perf_stalls)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    req_valid    = '0;
    req_op       = '0;
    req_wid      = '0;
    req_rs1      = '0;
    req_rs2      = '0;
    req_bar_addr = '0;
    done_valid   = 1'b0;
    done_ctx_idx = '0;
  endtask

  task automatic set_req(input int c, input logic [2:0] op, input logic [1:0] wid,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [7:0] bar);
    req_valid[c]    = 1'b1;
    req_op[c]       = op;
    req_wid[c]      = wid;
    req_rs1[c]      = rs1;
    req_rs2[c]      = rs2;
    req_bar_addr[c] = bar;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    launch_ready = 1'b0;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    settle();
    check_eq("rst_st_fire", st_fire, 0);
    check_eq("rst_launch_valid", launch_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_perf_launches", perf_launches, 0);
    check_eq("rst_perf_stalls", perf_stalls, 0);
    check_eq("rst_st_rs1", st_rs1, 0);

    // Core 0 warp 1 SETUP0, rs1=3
    set_req(0, 3'd0, 2'd1, 32'd3, 32'd7, 8'h5a);
    settle();
    check_eq("setup0_ready", req_ready, 2'b01);
    cyc();
    idle();
    settle();
    check_eq("setup0_st_fire", st_fire, 1);
    check_eq("setup0_st_op", st_op, 0);
    check_eq("setup0_st_ctx", st_ctx_idx, 1);
    check_eq("setup0_st_rs1", st_rs1, 3);
    check_eq("setup0_st_rs2", st_rs2, 7);
    check_eq("setup0_st_bar", st_bar_addr, 8'h5a);
    check_eq("setup0_no_launch", launch_valid, 0);
    cyc();
    settle();
    check_eq("setup0_st_fire_drop", st_fire, 0);

    // Round robin: both cores continuously valid with non-ISSUE ops
    do_reset();
    set_req(0, 3'd1, 2'd0, 32'd10, 32'd0, 8'd0);
    set_req(1, 3'd3, 2'd0, 32'd20, 32'd0, 8'd0);
    for (int n = 0; n < 4; n++) begin
      settle();
      check_eq($sformatf("rr_grant%0d", n), req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
    end
    idle();
    settle();
    check_eq("rr_last_st_ctx", st_ctx_idx, 4);

    // Outstanding context blocks further ops until done
    do_reset();
    set_req(0, 3'd4, 2'd2, 32'd1, 32'd2, 8'd3);
    settle();
    check_eq("out_issue_ready", req_ready, 2'b01);
    cyc();
    idle();
    set_req(0, 3'd0, 2'd2, 32'd9, 32'd0, 8'd0);
    settle();
    check_eq("out_launch_valid", launch_valid, 1);
    check_eq("out_launch_ctx", launch_ctx_idx, 2);
    check_eq("out_busy", busy, 1);
    check_eq("out_setup_stall0", req_ready, 2'b00);
    cyc();
    settle();
    check_eq("out_setup_stall1", req_ready, 2'b00);
    cyc();
    done_valid   = 1'b1;
    done_ctx_idx = 3'd2;
    settle();
    check_eq("out_same_cycle_done", req_ready, 2'b00);
    cyc();
    done_valid = 1'b0;
    settle();
    check_eq("out_after_done", req_ready, 2'b01);
    cyc();
    idle();
    settle();
    check_eq("out_busy_queue", busy, 1);

    // Full queue: ISSUE blocked, other-context COORD01 proceeds
    do_reset();
    begin
      int cores [4] = '{0, 1, 0, 1};
      int wids  [4] = '{0, 0, 1, 1};
      for (int n = 0; n < 4; n++) begin
        idle();
        set_req(cores[n], 3'd4, 2'(wids[n]), 32'(n), 32'd0, 8'd0);
        settle();
        check_eq($sformatf("full_fill%0d", n), req_ready, (cores[n] == 0) ? 2'b01 : 2'b10);
        cyc();
      end
    end
    idle();
    set_req(0, 3'd4, 2'd2, 32'd55, 32'd0, 8'd0);
    set_req(1, 3'd2, 2'd2, 32'd66, 32'd0, 8'd0);
    settle();
    check_eq("full_coord_only", req_ready, 2'b10);
    check_eq("full_head", launch_ctx_idx, 0);
    cyc();
    req_valid[1] = 1'b0;
    settle();
    check_eq("full_issue_stall", req_ready, 2'b00);
    check_eq("full_coord_st_op", st_op, 2);
    check_eq("full_coord_st_ctx", st_ctx_idx, 6);
    cyc();
    launch_ready = 1'b1;
    settle();
    check_eq("full_pop_still_blocks", req_ready, 2'b00);
    cyc();
    launch_ready = 1'b0;
    settle();
    check_eq("full_head_after_pop", launch_ctx_idx, 4);
    check_eq("full_fifth_accepted", req_ready, 2'b01);
    cyc();
    idle();
    settle();
    check_eq("full_fifth_st_op", st_op, 4);
    check_eq("full_fifth_st_ctx", st_ctx_idx, 2);

    // Reset with queued entries clears everything
    do_reset();
    set_req(0, 3'd4, 2'd0, 32'd0, 32'd0, 8'd0);
    cyc();
    idle();
    set_req(1, 3'd4, 2'd0, 32'd0, 32'd0, 8'd0);
    cyc();
    idle();
    settle();
    check_eq("mid_rst_pre_launch", launch_valid, 1);
    cyc();
    reset        = 1'b1;
    done_valid   = 1'b1;
    done_ctx_idx = 3'd0;
    cyc();
    reset      = 1'b0;
    done_valid = 1'b0;
    settle();
    check_eq("mid_rst_launch_valid", launch_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_st_fire", st_fire, 0);
    set_req(0, 3'd4, 2'd0, 32'd0, 32'd0, 8'd0);
    set_req(1, 3'd4, 2'd0, 32'd0, 32'd0, 8'd0);
    settle();
    check_eq("mid_rst_ctx0_again", req_ready, 2'b01);
    cyc();
    settle();
    check_eq("mid_rst_ctx4_again", req_ready, 2'b10);
    cyc();
    idle();

    // Performance counters: 3 launches, 5 stall cycles
    do_reset();
    launch_ready = 1'b1;
    set_req(0, 3'd4, 2'd0, 32'd0, 32'd0, 8'd0);
    cyc();
    repeat (5) cyc();
    idle();
    set_req(0, 3'd4, 2'd1, 32'd0, 32'd0, 8'd0);
    cyc();
    idle();
    set_req(0, 3'd4, 2'd2, 32'd0, 32'd0, 8'd0);
    cyc();
    idle();
    cyc();
    cyc();
    settle();
`ifdef VX_TMA_ISSUE_PERF_EN
    check_eq("perf_launches", perf_launches, 3);
    check_eq("perf_stalls", perf_stalls, 5);
`else
    check_eq("perf_launches", perf_launches, 0);
    check_eq("perf_stalls", perf_stalls, 0);
`endif
    check_eq("perf_queue_drained", launch_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
